// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest requester vector the helpers are written for.
    localparam int MAX_REQ = 16;

    // Width of the hold counter used by the optional timeout.
    localparam int HOLD_W = 8;

    // Index width for an n-requester arbiter; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Rotate an n-bit one-hot vector left by one, bit n-1 wrapping to bit 0.
    function automatic logic [MAX_REQ-1:0] rotl1(input logic [MAX_REQ-1:0] v, input int n);
        logic [MAX_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                r[(i + 1 == n) ? 0 : i + 1] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_ring_ptr.sv
// One-hot priority pointer: resets to requester 0 and, on advance,
// loads the released grant rotated left by one so its owner drops to
// lowest priority.
module rr_ring_ptr
    import rr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         advance,
    input  logic [N-1:0] grant,
    output logic [N-1:0] ptr
);

    // Ring register: async reset to 1, rotate-load on release only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= N'(1);
        end else if (advance) begin
            ptr <= N'(rotl1(MAX_REQ'(grant), N));
        end
    end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with one-hot rotating priority and registered
// one-hot grant. Grant is held while the winner keeps requesting.
// Optional forced release after MAX_HOLD grant cycles is compiled in
// with the macro RR_RING_ARBITER_TIMEOUT_EN; without it timeout is 0.
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDX_W    = idx_width(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout
);

    arb_state_t       state;
    logic [N-1:0]     ptr;
    logic [IDX_W-1:0] ptr_pos;
    logic [N-1:0]     sel;
    logic [IDX_W-1:0] sel_idx;
    logic             found;
    logic             req_held;
    logic             force_rel;
    logic             release_now;

    function automatic int wrap_add(input int p, input int k);
        return (p + k >= N) ? p + k - N : p + k;
    endfunction

    // Binary position of the one-hot priority pointer.
    always_comb begin
        ptr_pos = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr[i]) ptr_pos = IDX_W'(i);
        end
    end

    // First requester at or above the pointer, wrapping past N-1 to 0.
    always_comb begin
        sel     = '0;
        sel_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_add(int'(ptr_pos), k)]) begin
                found                            = 1'b1;
                sel[wrap_add(int'(ptr_pos), k)]  = 1'b1;
                sel_idx                          = IDX_W'(wrap_add(int'(ptr_pos), k));
            end
        end
    end

    assign req_held = |(req & grant);

`ifdef RR_RING_ARBITER_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic              timeout_q;

    assign force_rel = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign timeout   = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    assign release_now = (state == GRANT) && (force_rel || !req_held);

    rr_ring_ptr #(.N(N)) u_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (release_now),
        .grant   (grant),
        .ptr     (ptr)
    );

    // Arbitration FSM with registered grant, index, busy and timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RR_RING_ARBITER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= sel;
                        grant_idx <= sel_idx;
                        busy      <= 1'b1;
                        state     <= GRANT;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant     <= '0;
                        grant_idx <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
                        timeout_q <= force_rel;
`endif
                    end else begin
`ifdef RR_RING_ARBITER_TIMEOUT_EN
                        hold_cnt  <= hold_cnt + 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Self-checking bench for rr_ring_arbiter (N=4, MAX_HOLD=3).
module tb_rr_ring_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 3;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] req     = '0;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         busy;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 when idle), priority position,
    // cycles already held, and the timeout flag of the current cycle.
    int m_own  = -1;
    int m_pos  = 0;
    int m_held = 0;
    bit m_to   = 1'b0;

    function automatic void model_step(input logic [N-1:0] r, input int own, input int pos,
                                       input int held, output int n_own, output int n_pos,
                                       output int n_held, output bit n_to);
        bit lim;
        lim    = 1'b0;
        n_own  = own;
        n_pos  = pos;
        n_held = held;
        n_to   = 1'b0;
        if (own < 0) begin
            for (int k = 0; k < N; k++) begin
                if (n_own < 0 && r[(pos + k) % N]) begin
                    n_own  = (pos + k) % N;
                    n_held = 0;
                end
            end
        end else begin
            n_held = held + 1;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
            lim = (n_held >= MAX_HOLD);
`endif
            if (lim || !r[own]) begin
                n_own = -1;
                n_pos = (own + 1) % N;
                n_to  = lim;
            end
        end
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        return (i >= 0) ? N'(1 << i) : '0;
    endfunction

    int nx_own, nx_pos, nx_held;
    bit nx_to;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_own  <= -1;
            m_pos  <= 0;
            m_held <= 0;
            m_to   <= 1'b0;
        end else begin
            model_step(req, m_own, m_pos, m_held, nx_own, nx_pos, nx_held, nx_to);
            m_own  <= nx_own;
            m_pos  <= nx_pos;
            m_held <= nx_held;
            m_to   <= nx_to;
        end
    end

    always @(negedge clk) begin
        chk("model_grant", 32'(grant), 32'(onehot(m_own)));
        chk("model_idx", 32'(grant_idx), (m_own >= 0) ? 32'(m_own) : 32'd0);
        chk("model_busy", 32'(busy), 32'(m_own >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_to));
        chk("model_ptr", 32'(dut.u_ptr.ptr), 32'(onehot(m_pos)));
    end

    logic [N-1:0] fair_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        // Reset with all requesting
        req = 4'b1111;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_ptr", 32'(dut.u_ptr.ptr), 32'h1);
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_idx", 32'(grant_idx), 32'h0);

        // Fairness: each winner releases after one grant cycle
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 4 && !busy; w++) @(negedge clk);
            chk("fair_grant", 32'(grant), 32'(fair_exp[r]));
            req = 4'b1111 & ~fair_exp[r];
            @(negedge clk);
            chk("fair_idle", 32'(grant), 32'h0);
            req = 4'b1111;
            @(negedge clk);
        end

        // req=0101, drop requester 0, requester 2 wins next
        reset_n = 1'b0;
        req = 4'b0101;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("s2_grant0", 32'(grant), 32'h1);
        req = 4'b0100;
        @(negedge clk);
        chk("s2_release", 32'(grant), 32'h0);
        chk("s2_ptr", 32'(dut.u_ptr.ptr), 32'h2);
        @(negedge clk);
        chk("s2_grant2", 32'(grant), 32'h4);
        chk("s2_idx2", 32'(grant_idx), 32'h2);

        // Wrap-around from ptr=1000
        req = 4'b0011;
        @(negedge clk);
        chk("wrap_release", 32'(grant), 32'h0);
        chk("wrap_ptr", 32'(dut.u_ptr.ptr), 32'h8);
        @(negedge clk);
        chk("wrap_grant", 32'(grant), 32'h1);
        chk("wrap_idx", 32'(grant_idx), 32'h0);

        // Hold with req=0001 constant
        reset_n = 1'b0;
        req = 4'b0001;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("hold_c1", 32'(grant), 32'h1);
`ifdef RR_RING_ARBITER_TIMEOUT_EN
        @(negedge clk);
        chk("hold_c2", 32'(grant), 32'h1);
        @(negedge clk);
        chk("hold_c3", 32'(grant), 32'h1);
        chk("hold_c3_to", 32'(timeout), 32'h0);
        @(negedge clk);
        chk("to_grant", 32'(grant), 32'h0);
        chk("to_pulse", 32'(timeout), 32'h1);
        @(negedge clk);
        chk("to_regrant", 32'(grant), 32'h1);
        chk("to_clear", 32'(timeout), 32'h0);
`else
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_grant", 32'(grant), 32'h1);
            chk("hold_timeout", 32'(timeout), 32'h0);
        end
`endif

        // Async reset in the middle of a grant=0100 cycle
        reset_n = 1'b0;
        req = 4'b0100;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ar_grant", 32'(grant), 32'h4);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_async_grant", 32'(grant), 32'h0);
        chk("ar_async_busy", 32'(busy), 32'h0);
        chk("ar_async_idx", 32'(grant_idx), 32'h0);
        chk("ar_async_ptr", 32'(dut.u_ptr.ptr), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ar_regrant", 32'(grant), 32'h4);
        chk("ar_regrant_idx", 32'(grant_idx), 32'h2);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_ring_arbiter.md
# rr_ring_arbiter

Round-robin arbiter that shares one resource among N requesters using a one-hot rotating priority pointer. It sits in front of any shared sequential datapath, such as a shift/ring register bank or a shared load port, and issues exactly one registered one-hot grant at a time. A grant is held for as long as the winning requester keeps its request high. An optional hold-timeout forces fairness against requesters that never release.

## Interface
- N, 4, number of requesters (2..16)
- MAX_HOLD, 8, maximum consecutive grant cycles when timeout is compiled in (1..255)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req  in  N  request per requester, level-sensitive
- grant  out  N  one-hot grant, or all-zero when idle
- grant_idx  out  $clog2(N)  binary index of grant, 0 when idle
- busy  out  1  high while any grant is asserted
- timeout  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE and GRANT. Reset state is IDLE.
- Reset values:
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - Priority pointer ptr=1 (requester 0 highest).
- IDLE:
  - If req≠0, select the first set req bit scanning from the ptr position upward with wrap to index 0 (indices ptr_pos, ptr_pos+1, …, N-1, 0, …).
  - Register grant to that bit and move to GRANT.
  - If req=0, stay in IDLE with grant=0.
- GRANT:
  - Hold grant unchanged while req[granted] is sampled 1.
  - When req[granted] is sampled 0: grant←0, ptr←grant rotated left by one (wrap N-1→0), state←IDLE.
  - Other req bits are ignored while in GRANT. No preemption.
- At most one grant bit is ever set. grant_idx and busy are always consistent with grant in the same cycle.
- Requests arriving while in GRANT wait; no request is lost as long as it is held high.
- A requester that drops req before being granted is simply not selected. There is no request latching.
- ptr advances only on release, never in IDLE with req=0.
- Reset asserted mid-GRANT: grant, busy and timeout clear immediately (asynchronously), and ptr returns to 1.

## Timing
- Request to grant: req sampled at edge k in IDLE gives grant valid after edge k (1-cycle latency).
- Release: req[g] sampled 0 at edge k gives grant=0 after edge k.
- Minimum one IDLE cycle between consecutive grants, so back-to-back ownership costs 2 edges from release sample to next grant.
- All outputs are registered. There is no combinational path from req to any output.

## Configuration
- Macro: RR_RING_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - After grant has been high for MAX_HOLD cycles, release is forced at the next edge even if req[g]=1. This follows the normal release path: grant←0, ptr rotates, state IDLE.
  - timeout pulses high for exactly that cycle (coincident with grant going 0).
  - A requester still requesting re-competes at lowest priority.
  - A voluntary release on the same edge as the limit counts as a timeout. Timeout has priority and the pulse fires.
- Undefined:
  - No counter is built.
  - timeout is tied 0.
  - A grant is held indefinitely.

## Structure
- Package rr_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the localparam for index width;
  - the one-hot rotate-left function;
  - the hold-counter width constant.
- Sub-module rr_ring_ptr: an N-bit one-hot ring register with async reset to 1 and a synchronous advance input that loads the rotated grant.
- The top level holds the FSM, the wrap-around priority select, the index encoder and the optional hold counter.

## Test plan
(N=4, MAX_HOLD=3)
- Reset with req=1111 held → grant=0000, busy=0, ptr=0001. First edge after release of reset_n → grant=0001, grant_idx=0.
- req=0101, grant=0001; drop req[0] → next edge grant=0000, ptr=0010; following edge grant=0100, grant_idx=2.
- Wrap-around: ptr=1000 (after releasing requester 2), req=0011 → grant=0001, not 0010.
- Fairness: req=1111 held, each winner releases after 1 cycle of grant → grant order 0001, 0010, 0100, 1000, 0001, with an idle cycle between each.
- Timeout (macro defined): req=0001 held constant → grant=0001 for exactly 3 cycles, then grant=0000 with timeout=1 for one cycle, then grant=0001 again. Without the macro, grant stays 0001 indefinitely and timeout=0.
- Async reset_n low in the middle of a grant=0100 cycle → grant=0000 immediately without waiting for clk. After release with req=0100 → grant=0100 after one edge, ptr was restored to 0001.
